// File: rtl/rc_op_sequencer.sv
// rc_op_sequencer: computes A+B-C in two passes through a shared 8-bit adder.
// Optional RC_SAT_EN: saturate out_res on overflow instead of wrapping.
module rc_op_sequencer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [WIDTH-1:0] in_c,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_res,
   output logic             out_ovf,
   output logic [WIDTH-1:0] as_x,
   output logic [WIDTH-1:0] as_y,
   output logic [2:0]       as_s,
   input  logic [WIDTH-1:0] as_g,
   input  logic             as_cout
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      SUB  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] ra;
   logic [WIDTH-1:0] rb;
   logic [WIDTH-1:0] rc;
   logic [WIDTH-1:0] t_q;
   logic             k1_q;
   logic [1:0]       hsum;
   logic             u_msb;
   logic             fit;
   logic [WIDTH-1:0] res_nxt;
`ifdef RC_SAT_EN
   logic             pos_ovf;
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state, handshake flags and adder drive
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      as_x      = '0;
      as_y      = '0;
      as_s      = 3'b000;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = ADD;
         end
         ADD: begin
            as_x      = ra;
            as_y      = rb;
            as_s      = 3'b010;
            state_nxt = SUB;
         end
         SUB: begin
            as_x      = t_q;
            as_y      = rc;
            as_s      = 3'b101;
            state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Range check of V = 2^WIDTH*h + U from the SUB-pass adder result
   always_comb begin
      hsum  = {1'b0, k1_q} + {1'b0, as_cout};
      u_msb = as_g[WIDTH-1];
      fit   = ((hsum == 2'd1) && !u_msb) ||
              ((hsum == 2'd0) && u_msb);
`ifdef RC_SAT_EN
      pos_ovf = (hsum == 2'd2) ||
                ((hsum == 2'd1) && u_msb);
      if (fit) begin
         res_nxt = as_g;
      end else if (pos_ovf) begin
         res_nxt = {1'b0, {(WIDTH-1){1'b1}}};
      end else begin
         res_nxt = {1'b1, {(WIDTH-1){1'b0}}};
      end
`else
      res_nxt = as_g;
`endif
   end

   // Operand latch, first-pass capture and result register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ra      <= '0;
         rb      <= '0;
         rc      <= '0;
         t_q     <= '0;
         k1_q    <= 1'b0;
         out_res <= '0;
         out_ovf <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  ra <= in_a;
                  rb <= in_b;
                  rc <= in_c;
               end
            end
            ADD: begin
               t_q  <= as_g;
               k1_q <= as_cout;
            end
            SUB: begin
               out_res <= res_nxt;
               out_ovf <= !fit;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rc_op_sequencer.sv
// tb_rc_op_sequencer: vector table, random triples vs. arithmetic model,
// backpressure and mid-operation reset sequences.
module tb_rc_op_sequencer;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_a;
   logic [7:0] in_b;
   logic [7:0] in_c;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_res;
   logic       out_ovf;
   logic [7:0] as_x;
   logic [7:0] as_y;
   logic [2:0] as_s;
   logic [7:0] as_g;
   logic       as_cout;

   int checks;
   int failures;

   rc_op_sequencer #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_c      (in_c),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_res   (out_res),
      .out_ovf   (out_ovf),
      .as_x      (as_x),
      .as_y      (as_y),
      .as_s      (as_s),
      .as_g      (as_g),
      .as_cout   (as_cout)
   );

   // Behavioural shared adder/subtractor
   logic [7:0] y_op;
   assign y_op = as_s[1] ? as_y : (as_s[2] ? ~as_y : 8'h00);
   assign {as_cout, as_g} = {1'b0, as_x} + {1'b0, y_op} + {8'h00, as_s[0]};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] c;
      logic [7:0] res;
      logic       ovf;
   } vec_t;

   vec_t vt[6];

   task automatic chk(input string n, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", n, act, exp);
      end
   endtask

   // Reference: exact integer V, then range check
   task automatic model(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, output logic [7:0] r,
                        output logic o);
      int v;
      v = int'(a) + int'(b) - int'(c);
      o = (v > 127) || (v < -128);
`ifdef RC_SAT_EN
      if (v > 127) r = 8'h7F;
      else if (v < -128) r = 8'h80;
      else r = v[7:0];
`else
      r = v[7:0];
`endif
   endtask

   task automatic run(input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] c, input logic [7:0] er,
                      input logic eo, input int hold);
      logic [7:0] sum;
      sum = a + b;
      in_a = a;
      in_b = b;
      in_c = c;
      in_valid = 1'b1;
      out_ready = 1'b0;
      chk("idle_in_ready", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      in_a = 8'($urandom);
      in_b = 8'($urandom);
      in_c = 8'($urandom);
      chk("add_as_s", as_s, 3'b010);
      chk("add_as_x", as_x, a);
      chk("add_as_y", as_y, b);
      chk("add_busy", {in_ready, out_valid}, 0);
      @(negedge clk);
      chk("sub_as_s", as_s, 3'b101);
      chk("sub_as_x", as_x, sum);
      chk("sub_as_y", as_y, c);
      chk("sub_out_valid", out_valid, 0);
      @(negedge clk);
      chk("done_out_valid", out_valid, 1);
      chk("done_out_res", out_res, er);
      chk("done_out_ovf", out_ovf, eo);
      chk("done_as_s", as_s, 0);
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1;
         in_a = 8'($urandom);
         in_b = 8'($urandom);
         in_c = 8'($urandom);
         @(negedge clk);
         chk("hold_out_valid", out_valid, 1);
         chk("hold_out_res", out_res, er);
         chk("hold_out_ovf", out_ovf, eo);
         chk("hold_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      in_valid = 1'b0;
      chk("ret_out_valid", out_valid, 0);
      chk("ret_in_ready", in_ready, 1);
   endtask

   initial begin
      logic [7:0] r;
      logic       o;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] c;
      checks = 0;
      failures = 0;

      vt[0] = '{8'd10,  8'd20,  8'd5,   8'h19, 1'b0};
`ifdef RC_SAT_EN
      vt[1] = '{8'd100, 8'd100, 8'd0,   8'h7F, 1'b1};
      vt[2] = '{8'd0,   8'd0,   8'd200, 8'h80, 1'b1};
      vt[3] = '{8'd255, 8'd255, 8'd255, 8'h7F, 1'b1};
`else
      vt[1] = '{8'd100, 8'd100, 8'd0,   8'hC8, 1'b1};
      vt[2] = '{8'd0,   8'd0,   8'd200, 8'h38, 1'b1};
      vt[3] = '{8'd255, 8'd255, 8'd255, 8'hFF, 1'b1};
`endif
      vt[4] = '{8'd0,   8'd0,   8'd128, 8'h80, 1'b0};
      vt[5] = '{8'd127, 8'd0,   8'd0,   8'h7F, 1'b0};

      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      in_a = 8'h00;
      in_b = 8'h00;
      in_c = 8'h00;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_res", out_res, 0);
      chk("rst_out_ovf", out_ovf, 0);
      chk("rst_adder", {as_x, as_y, 5'(as_s)}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         run(vt[i].a, vt[i].b, vt[i].c, vt[i].res, vt[i].ovf, 0);
      end

      // Backpressure: 5 stalled cycles with in_valid pulses
      run(8'd100, 8'd100, 8'd0, vt[1].res, 1'b1, 5);

      // Reset during SUB: abort, no result
      in_a = 8'd60;
      in_b = 8'd70;
      in_c = 8'd3;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      chk("pre_rst_in_sub", as_s, 3'b101);
      rst_n = 1'b0;
      #1;
      chk("abort_in_ready", in_ready, 1);
      chk("abort_out_valid", out_valid, 0);
      chk("abort_out_res", out_res, 0);
      chk("abort_out_ovf", out_ovf, 0);
      chk("abort_as_s", as_s, 0);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("abort_no_emit", out_valid, 0);
      end
      out_ready = 1'b0;

      // Random triples against the arithmetic model
      for (int i = 0; i < 40; i++) begin
         a = 8'($urandom);
         b = 8'($urandom);
         c = 8'($urandom);
         model(a, b, c, r, o);
         run(a, b, c, r, o, int'($urandom_range(0, 2)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
